// File: rtl/imem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// imem_ctrl_pkg
//   Shared definitions for the instruction-memory controller:
//     - state_e           : controller states FILL / BOOT / RUN
//     - AW_DEFAULT        : default word-address width (2^AW words)
//     - NOP_WORD_DEFAULT  : fill value, addi x0,x0,0
//     - REQ_FETCH/REQ_LD  : requester indices on the arbiter vectors
//     - is_misaligned()   : byte address not on a word boundary
// ---------------------------------------------------------------------------
package imem_ctrl_pkg;

  localparam int unsigned AW_DEFAULT       = 10;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  localparam int unsigned REQ_FETCH = 0;
  localparam int unsigned REQ_LD    = 1;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    BOOT = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/imem_ctrl_rr.sv
// ---------------------------------------------------------------------------
// imem_rr_arb
//   Two-requester round-robin arbiter. On a conflict the requester that did
//   not win last time is granted; a lone requester is granted directly.
//   Grants are purely combinational from req_i and the last-winner flag.
//
//   Ports:
//     clk     in  : clock, posedge
//     rst_n   in  : synchronous active-low reset (last winner := loader)
//     req_i   in  : [REQ_FETCH] fetch request, [REQ_LD] loader request
//     gnt_o   out : one-hot (or zero) grant, same bit order as req_i
// ---------------------------------------------------------------------------
module imem_rr_arb
  import imem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_ld_q;
  logic last_ld_d;

  always_comb begin
    gnt_o     = req_i;
    last_ld_d = last_ld_q;
    if (req_i == 2'b11) begin
      gnt_o = 2'b00;
      if (last_ld_q) begin
        gnt_o[REQ_FETCH] = 1'b1;
      end else begin
        gnt_o[REQ_LD] = 1'b1;
      end
    end
    if (|gnt_o) begin
      last_ld_d = gnt_o[REQ_LD];
    end
  end

  // Loader counts as last winner after reset so fetch takes the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_ld_q <= 1'b1;
    end else begin
      last_ld_q <= last_ld_d;
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// ---------------------------------------------------------------------------
// imem_ctrl
//   Instruction-memory controller in front of a single-port SRAM with a
//   one-cycle synchronous read. Two masters share the SRAM: the core fetch
//   port and a boot-loader/debug port.
//
//   States:
//     FILL : write NOP_WORD to every word, one per cycle (optional feature)
//     BOOT : only the loader is served; ld_done moves on to RUN
//     RUN  : fetch and loader share the SRAM round-robin
//
//   Configuration macro: IMEM_CTRL_FILL_EN
//     defined   -> FILL state and fill counter exist, reset enters FILL
//     undefined -> no FILL, reset enters BOOT, SRAM contents unspecified
//
//   Ports:
//     clk, rst_n                      clock / synchronous active-low reset
//     fetch_req, fetch_addr           fetch request and byte address
//     fetch_gnt                       fetch granted this cycle (comb)
//     fetch_rvalid, fetch_rdata       read data, one cycle after grant
//     fetch_err                       granted fetch was misaligned
//     ld_req, ld_we, ld_addr,
//     ld_wdata                        loader request/write/address/data
//     ld_gnt                          loader granted this cycle (comb)
//     ld_rvalid, ld_rdata             loader read data, one cycle later
//     ld_done                         loader finished (honoured in BOOT)
//     mem_en, mem_we, mem_addr,
//     mem_wdata, mem_rdata            SRAM port
//     busy                            state is not RUN (or in reset)
// ---------------------------------------------------------------------------
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned AW       = AW_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  // fetch port
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_rdata,
  output logic          fetch_err,
  // loader port
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [31:0]   ld_rdata,
  input  logic          ld_done,
  // SRAM port
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  // status
  output logic          busy
);

  state_e        state_q;
  state_e        state_d;
  logic          in_boot;
  logic          in_run;
  logic          fill_act;
  logic [1:0]    arb_req;
  logic [1:0]    arb_gnt;
  logic [AW-1:0] fetch_widx;
  logic [AW-1:0] ld_widx;

  // read pipeline: pending valid / error for the cycle after a grant,
  // plus hold registers so rdata and fetch_err stay put between pulses
  logic          fetch_vld_q;
  logic          fetch_mis_q;
  logic          ld_vld_q;
  logic [31:0]   fetch_rdata_q;
  logic          fetch_err_q;
  logic [31:0]   ld_rdata_q;

`ifdef IMEM_CTRL_FILL_EN
  localparam state_e RST_STATE = FILL;
  logic [AW-1:0] fill_cnt_q;
  logic [AW-1:0] fill_cnt_d;
  assign fill_act = rst_n && (state_q == FILL);
`else
  localparam state_e RST_STATE = BOOT;
  assign fill_act = 1'b0;
`endif

  // Upper address bits alias by design; loader byte offset is don't-care.
  logic sig_unused;
`ifdef IMEM_CTRL_FILL_EN
  assign sig_unused = ^{fetch_addr[31:AW+2], ld_addr[31:AW+2], ld_addr[1:0]};
`else
  assign sig_unused = ^{fetch_addr[31:AW+2], ld_addr[31:AW+2], ld_addr[1:0],
                        NOP_WORD};
`endif

  assign fetch_widx = fetch_addr[AW+1:2];
  assign ld_widx    = ld_addr[AW+1:2];

  // Grants are gated by rst_n so nothing reaches the SRAM during reset.
  assign in_boot = rst_n && (state_q == BOOT);
  assign in_run  = rst_n && (state_q == RUN);
  assign busy    = !rst_n || (state_q != RUN);

  always_comb begin
    arb_req            = 2'b00;
    arb_req[REQ_FETCH] = in_run & fetch_req;
    arb_req[REQ_LD]    = in_run & ld_req;
  end

  imem_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (arb_req),
    .gnt_o (arb_gnt)
  );

  assign fetch_gnt = arb_gnt[REQ_FETCH];
  assign ld_gnt    = in_boot ? ld_req : arb_gnt[REQ_LD];

  // SRAM request mux: fill writes, else whichever port was granted.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fill_act) begin
`ifdef IMEM_CTRL_FILL_EN
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = fill_cnt_q;
      mem_wdata = NOP_WORD;
`endif
    end else if (fetch_gnt) begin
      mem_en   = 1'b1;
      mem_addr = fetch_widx;
    end else if (ld_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ld_we;
      mem_addr  = ld_widx;
      mem_wdata = ld_wdata;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
`ifdef IMEM_CTRL_FILL_EN
    fill_cnt_d = fill_cnt_q;
`endif
    case (state_q)
`ifdef IMEM_CTRL_FILL_EN
      FILL: begin
        fill_cnt_d = fill_cnt_q + 1'b1;
        if (fill_cnt_q == '1) begin
          state_d = BOOT;
        end
      end
`endif
      BOOT: begin
        if (ld_done) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
`ifdef IMEM_CTRL_FILL_EN
      fill_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef IMEM_CTRL_FILL_EN
      fill_cnt_q <= fill_cnt_d;
`endif
    end
  end

  // Grant -> rvalid stage; SRAM data arrives in the rvalid cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_vld_q   <= 1'b0;
      fetch_mis_q   <= 1'b0;
      ld_vld_q      <= 1'b0;
      fetch_rdata_q <= '0;
      fetch_err_q   <= 1'b0;
      ld_rdata_q    <= '0;
    end else begin
      fetch_vld_q <= fetch_gnt;
      fetch_mis_q <= fetch_gnt & is_misaligned(fetch_addr[1:0]);
      ld_vld_q    <= ld_gnt & ~ld_we;
      if (fetch_vld_q) begin
        fetch_rdata_q <= mem_rdata;
        fetch_err_q   <= fetch_mis_q;
      end
      if (ld_vld_q) begin
        ld_rdata_q <= mem_rdata;
      end
    end
  end

  // In the pulse cycle present live SRAM data, otherwise the held copy.
  assign fetch_rvalid = fetch_vld_q;
  assign fetch_rdata  = fetch_vld_q ? mem_rdata   : fetch_rdata_q;
  assign fetch_err    = fetch_vld_q ? fetch_mis_q : fetch_err_q;
  assign ld_rvalid    = ld_vld_q;
  assign ld_rdata     = ld_vld_q ? mem_rdata : ld_rdata_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_ctrl
//   Self-checking bench for imem_ctrl (AW=10). A behavioural SRAM sits on
//   the memory port; a reference model tracks the controller phase, the
//   round-robin owner, the expected memory image and the outstanding reads
//   and is compared against the DUT every cycle. Honours IMEM_CTRL_FILL_EN.
// ---------------------------------------------------------------------------
module tb_imem_ctrl;

  localparam int          AW    = 10;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          P_FILL = 0;
  localparam int          P_BOOT = 1;
  localparam int          P_RUN  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_gnt;
  logic          fetch_rvalid;
  logic [31:0]   fetch_rdata;
  logic          fetch_err;
  logic          ld_req;
  logic          ld_we;
  logic [31:0]   ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [31:0]   ld_rdata;
  logic          ld_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;

  imem_ctrl #(.AW(AW), .NOP_WORD(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .fetch_err    (fetch_err),
    .ld_req       (ld_req),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_wdata     (ld_wdata),
    .ld_gnt       (ld_gnt),
    .ld_rvalid    (ld_rvalid),
    .ld_rdata     (ld_rdata),
    .ld_done      (ld_done),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // single-port SRAM, one-cycle synchronous read
  logic [31:0] sram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  bit          started = 0;
  int          phase;
  int          fill_idx;
  bit          last_ld;
  logic [31:0] gold  [DEPTH];
  bit          known [DEPTH];
  bit          pf, pl, pf_err, pf_known, pl_known;
  logic [31:0] pf_data, pl_data;
  logic [31:0] hf_data, hl_data;
  bit          hf_err, hf_known, hl_known;
  int          n_fill_wr;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[11:8] = 4'h0;
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic rand_inputs(input bit allow_done);
    fetch_req  = 1'($urandom_range(0, 1));
    fetch_addr = rand_addr();
    ld_req     = 1'($urandom_range(0, 1));
    ld_we      = 1'($urandom_range(0, 1));
    ld_addr    = rand_addr();
    ld_wdata   = $urandom;
    ld_done    = allow_done ? ($urandom_range(0, 15) == 0) : 1'b0;
  endtask

  // One clock: inputs already applied; check at negedge, update at posedge.
  task automatic step();
    bit ef, el;
    int fa, la, cur;
    @(negedge clk);
    fa = widx(fetch_addr);
    la = widx(ld_addr);
    ef = 0;
    el = 0;
    if (rst_n && started) begin
      if (phase == P_BOOT) begin
        el = ld_req;
      end else if (phase == P_RUN) begin
        if (fetch_req && ld_req) begin
          ef = last_ld;
          el = !last_ld;
        end else begin
          ef = fetch_req;
          el = ld_req;
        end
      end
    end
    if (started) begin
      check("fetch_gnt", 32'(fetch_gnt), 32'(ef));
      check("ld_gnt", 32'(ld_gnt), 32'(el));
      check("busy", 32'(busy), 32'(!rst_n || phase != P_RUN));
      if (rst_n && phase == P_FILL) begin
        check("fill_en", 32'(mem_en), 32'd1);
        check("fill_we", 32'(mem_we), 32'd1);
        check("fill_addr", 32'(mem_addr), 32'(fill_idx));
        check("fill_wdata", mem_wdata, NOP);
        if (mem_en && mem_we && mem_wdata == NOP && int'(mem_addr) == fill_idx)
          n_fill_wr++;
      end else begin
        check("mem_en", 32'(mem_en), 32'(ef || el));
        check("mem_we", 32'(mem_we), 32'(el && ld_we));
        if (ef) check("mem_addr_f", 32'(mem_addr), 32'(fa));
        if (el) check("mem_addr_l", 32'(mem_addr), 32'(la));
        if (el && ld_we) check("mem_wdata", mem_wdata, ld_wdata);
      end
      check("fetch_rvalid", 32'(fetch_rvalid), 32'(pf));
      check("ld_rvalid", 32'(ld_rvalid), 32'(pl));
      if (pf ? pf_known : hf_known)
        check("fetch_rdata", fetch_rdata, pf ? pf_data : hf_data);
      check("fetch_err", 32'(fetch_err), 32'(pf ? pf_err : hf_err));
      if (pl ? pl_known : hl_known)
        check("ld_rdata", ld_rdata, pl ? pl_data : hl_data);
    end
    @(posedge clk);
    if (!rst_n) begin
`ifdef IMEM_CTRL_FILL_EN
      phase = P_FILL;
`else
      phase = P_BOOT;
`endif
      fill_idx  = 0;
      last_ld   = 1;
      pf        = 0;
      pl        = 0;
      hf_data   = '0;
      hl_data   = '0;
      hf_err    = 0;
      hf_known  = 1;
      hl_known  = 1;
      n_fill_wr = 0;
      started   = 1;
    end else if (started) begin
      cur = phase;
      if (pf) begin
        hf_data  = pf_data;
        hf_err   = pf_err;
        hf_known = pf_known;
      end
      if (pl) begin
        hl_data  = pl_data;
        hl_known = pl_known;
      end
      pf       = ef;
      pf_data  = gold[fa];
      pf_known = known[fa];
      pf_err   = (fetch_addr[1:0] != 2'b00);
      pl       = el && !ld_we;
      pl_data  = gold[la];
      pl_known = known[la];
      if (cur == P_FILL) begin
        gold[fill_idx]  = NOP;
        known[fill_idx] = 1;
        if (fill_idx == DEPTH - 1) phase = P_BOOT;
        fill_idx = (fill_idx + 1) % DEPTH;
      end
      if (el && ld_we) begin
        gold[la]  = ld_wdata;
        known[la] = 1;
      end
      if (cur == P_RUN && (ef || el)) last_ld = el;
      if (cur == P_BOOT && ld_done) phase = P_RUN;
    end
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    ld_req     = 1'b0;
    ld_we      = 1'b0;
    ld_addr    = '0;
    ld_wdata   = '0;
    ld_done    = 1'b0;

    // reset state
    step();
    step();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_fetch_rvalid", 32'(fetch_rvalid), 32'd0);
    check("rst_fetch_rdata", fetch_rdata, 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    check("rst_ld_rdata", ld_rdata, 32'd0);

`ifdef IMEM_CTRL_FILL_EN
    // partial fill, reset at counter 500, then a full uninterrupted fill
    rst_n = 1'b1;
    for (int i = 0; i < 600 && fill_idx != 500; i++) begin
      rand_inputs(1'b1);
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("refill_addr", 32'(mem_addr), 32'd0);
    check("refill_we", 32'(mem_we), 32'd1);
    for (int i = 0; i < DEPTH + 10 && phase == P_FILL; i++) begin
      rand_inputs(1'b1);
      step();
    end
    check("fill_writes", 32'(n_fill_wr), 32'(DEPTH));
`else
    rst_n = 1'b1;
`endif

    // BOOT: fetch locked out, loader write then read back
    fetch_req = 1'b1; ld_req = 1'b0; ld_done = 1'b0; fetch_addr = 32'h4;
    #1;
    check("boot_fetch_gnt", 32'(fetch_gnt), 32'd0);
    check("boot_busy", 32'(busy), 32'd1);
    step();
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h10; ld_wdata = 32'hDEAD_BEEF;
    #1;
    check("boot_ld_gnt", 32'(ld_gnt), 32'd1);
    step();
    ld_we = 1'b0;
    step();
    check("boot_ld_rvalid", 32'(ld_rvalid), 32'd1);
    check("boot_ld_rdata", ld_rdata, 32'hDEAD_BEEF);
    ld_req = 1'b0; fetch_req = 1'b0;
    step();
    check("ld_rdata_hold", ld_rdata, 32'hDEAD_BEEF);
    check("ld_rvalid_pulse", 32'(ld_rvalid), 32'd0);

    for (int i = 0; i < 200; i++) begin
      rand_inputs(1'b0);
      step();
    end

    // known word 0 for the alias test, then leave BOOT
    fetch_req = 1'b0; ld_req = 1'b1; ld_we = 1'b1;
    ld_addr = 32'h0; ld_wdata = 32'hCAFE_0000;
    step();
    ld_req = 1'b0; ld_done = 1'b1;
    step();
    ld_done = 1'b0;

    // RUN: both requesting for 4 cycles -> fetch, ld, fetch, ld
    fetch_req = 1'b1; fetch_addr = 32'h100;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h10;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i == 0) check("run_busy", 32'(busy), 32'd0);
      check("rr_fetch_gnt", 32'(fetch_gnt), 32'(i % 2 == 0));
      check("rr_ld_gnt", 32'(ld_gnt), 32'(i % 2 == 1));
      step();
      check("rr_fetch_rvalid", 32'(fetch_rvalid), 32'(i % 2 == 0));
      check("rr_ld_rvalid", 32'(ld_rvalid), 32'(i % 2 == 1));
    end

    // alias + misalignment
    ld_req = 1'b0; fetch_addr = 32'h1002;
    step();
    check("alias_rvalid", 32'(fetch_rvalid), 32'd1);
    check("alias_rdata", fetch_rdata, 32'hCAFE_0000);
    check("alias_err", 32'(fetch_err), 32'd1);
    fetch_addr = 32'h4;
    step();
    check("aligned_err", 32'(fetch_err), 32'd0);

    for (int i = 0; i < 1500; i++) begin
      rand_inputs(1'b1);
      step();
    end

    // reset right behind a granted read
    fetch_req = 1'b1; ld_req = 1'b0; ld_done = 1'b0; fetch_addr = 32'h8;
    step();
    fetch_req = 1'b0;
    rst_n = 1'b0;
    step();
    check("rst_drop_rvalid", 32'(fetch_rvalid), 32'd0);
    check("rst_drop_rdata", fetch_rdata, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
